// File: rtl/lcd_timing_pkg.sv
// Shared types, default panel timing and pixel-format helper for the LCD pixel timing block.
package lcd_timing_pkg;

    typedef enum logic [1:0] {
        RGN_ACTIVE = 2'd0,
        RGN_FP     = 2'd1,
        RGN_SYNC   = 2'd2,
        RGN_BP     = 2'd3
    } region_t;

    localparam int          DEF_H_ACTIVE = 480;
    localparam int          DEF_H_FP     = 2;
    localparam int          DEF_H_SYNC   = 41;
    localparam int          DEF_H_BP     = 2;
    localparam int          DEF_V_ACTIVE = 272;
    localparam int          DEF_V_FP     = 2;
    localparam int          DEF_V_SYNC   = 10;
    localparam int          DEF_V_BP     = 2;
    localparam logic [15:0] DEF_FILL_RGB = 16'h0000;

    function automatic int cnt_width(input int tot);
        return (tot > 1) ? $clog2(tot) : 1;
    endfunction

    // MSB replication keeps full-scale white at 8'hFF on every channel.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
        return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
    endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One timing axis: position counter with region decode and end-of-axis wrap strobe.
module lcd_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE = 8,
    parameter int FP     = 1,
    parameter int SYNC   = 2,
    parameter int BP     = 1,
    localparam int TOT   = ACTIVE + FP + SYNC + BP,
    localparam int CW    = cnt_width(TOT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output region_t       region,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST     = CW'(TOT - 1);
    localparam logic [CW-1:0] FP_START = CW'(ACTIVE);
    localparam logic [CW-1:0] SY_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] BP_START = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign wrap      = tick & w_at_last;
    assign cnt       = r_cnt;

    // Position register: clear has priority so a parked axis always restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Region decode from the current position.
    always_comb begin
        region = RGN_BP;
        if (r_cnt < FP_START) begin
            region = RGN_ACTIVE;
        end else if (r_cnt < SY_START) begin
            region = RGN_FP;
        end else if (r_cnt < BP_START) begin
            region = RGN_SYNC;
        end else begin
            region = RGN_BP;
        end
    end

endmodule

// File: rtl/lcd_pixel_timing.sv
// Parallel RGB LCD timing generator: pulls RGB565 pixels from upstream, drives
// HSYNC/VSYNC/DE/RGB888 one clock later and tracks underflow.
module lcd_pixel_timing
    import lcd_timing_pkg::*;
#(
    parameter int          H_ACTIVE = DEF_H_ACTIVE,
    parameter int          H_FP     = DEF_H_FP,
    parameter int          H_SYNC   = DEF_H_SYNC,
    parameter int          H_BP     = DEF_H_BP,
    parameter int          V_ACTIVE = DEF_V_ACTIVE,
    parameter int          V_FP     = DEF_V_FP,
    parameter int          V_SYNC   = DEF_V_SYNC,
    parameter int          V_BP     = DEF_V_BP,
    parameter logic [15:0] FILL_RGB = DEF_FILL_RGB
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    output logic        pixel_ready,
    input  logic        pixel_valid,
    input  logic [15:0] pixel_readdata,
    output logic        pixel_frame_sync,
    output logic        lcd_hsync_n,
    output logic        lcd_vsync_n,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic [15:0] underflow_cnt
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = cnt_width(H_TOT);
    localparam int VW    = cnt_width(V_TOT);

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    region_t       w_h_rgn;
    region_t       w_v_rgn;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_run;
    logic          w_clear;
    logic          w_ready;
    logic          w_sync_line;
    logic [15:0]   w_pix;

    logic          r_en_d;
    logic          r_de;
    logic          r_hsync_n;
    logic          r_vsync_n;
    logic [23:0]   r_rgb;
    logic          r_underflow;
    logic [15:0]   r_underflow_cnt;

    assign w_run   = enable & reset_reset_n;
    assign w_clear = ~enable;

    lcd_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .tick   (1'b1),
        .clear  (w_clear),
        .cnt    (w_h_cnt),
        .region (w_h_rgn),
        .wrap   (w_h_wrap)
    );

    lcd_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .tick   (w_h_wrap),
        .clear  (w_clear),
        .cnt    (w_v_cnt),
        .region (w_v_rgn),
        .wrap   (w_v_wrap)
    );

    assign w_ready     = w_run & (w_h_rgn == RGN_ACTIVE) & (w_v_rgn == RGN_ACTIVE);
    assign w_sync_line = (w_h_cnt == HW'(0)) & (w_v_cnt == VW'(V_ACTIVE));

    // The first enabled clock also rewinds upstream, so a restart always begins at pixel 0.
    assign pixel_ready      = w_ready;
    assign pixel_frame_sync = w_run & (~r_en_d | w_sync_line);

    // Source word for the current slot: upstream data or the fill colour on underflow.
    always_comb begin
        w_pix = FILL_RGB;
        if (pixel_valid) begin
            w_pix = pixel_readdata;
        end else begin
            w_pix = FILL_RGB;
        end
    end

    // Panel outputs, all registered from the same counter state.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_en_d    <= 1'b0;
            r_de      <= 1'b0;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
            r_rgb     <= 24'h000000;
        end else if (!enable) begin
            r_en_d    <= 1'b0;
            r_de      <= 1'b0;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
            r_rgb     <= 24'h000000;
        end else begin
            r_en_d    <= 1'b1;
            r_de      <= w_ready;
            r_hsync_n <= (w_h_rgn != RGN_SYNC);
            r_vsync_n <= (w_v_rgn != RGN_SYNC);
            r_rgb     <= w_ready ? rgb565_to_888(w_pix) : 24'h000000;
        end
    end

    // Sticky underflow tracking; survives enable toggles, clear wins over a new event.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_underflow     <= 1'b0;
            r_underflow_cnt <= 16'h0000;
        end else if (underflow_clr) begin
            r_underflow     <= 1'b0;
            r_underflow_cnt <= 16'h0000;
        end else if (w_ready && !pixel_valid) begin
            r_underflow <= 1'b1;
            if (r_underflow_cnt != 16'hFFFF) begin
                r_underflow_cnt <= r_underflow_cnt + 16'h0001;
            end
        end
    end

    assign lcd_de        = r_de;
    assign lcd_hsync_n   = r_hsync_n;
    assign lcd_vsync_n   = r_vsync_n;
    assign lcd_rgb       = r_rgb;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_underflow_cnt;

    // The frame boundary is tracked through the sync line decode instead of the V wrap.
    logic w_unused;
    assign w_unused = w_v_wrap;

endmodule

// File: tb/tb_lcd_pixel_timing.sv
// Randomized bench for lcd_pixel_timing with a frame-position reference model (small panel geometry).
module tb_lcd_pixel_timing;

    localparam int HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam logic [15:0] FILL = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pixel_ready;
    logic        pixel_valid;
    logic [15:0] pixel_readdata;
    logic        pixel_frame_sync;
    logic        lcd_hsync_n;
    logic        lcd_vsync_n;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        underflow;
    logic        underflow_clr;
    logic [15:0] underflow_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: linear clock position since the timing was (re)started.
    int          m_p;
    bit          m_en_prev;
    bit          e_de, e_hs_n, e_vs_n, e_uf;
    logic [23:0] e_rgb;
    int          e_ucnt;
    int          cyc = 0;

    always #5 clk = ~clk;

    lcd_pixel_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FILL_RGB(FILL)
    ) dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .enable           (enable),
        .pixel_ready      (pixel_ready),
        .pixel_valid      (pixel_valid),
        .pixel_readdata   (pixel_readdata),
        .pixel_frame_sync (pixel_frame_sync),
        .lcd_hsync_n      (lcd_hsync_n),
        .lcd_vsync_n      (lcd_vsync_n),
        .lcd_de           (lcd_de),
        .lcd_rgb          (lcd_rgb),
        .underflow        (underflow),
        .underflow_clr    (underflow_clr),
        .underflow_cnt    (underflow_cnt)
    );

    function automatic logic [23:0] expand(input logic [15:0] px);
        int r, g, b;
        r = int'(px[15:11]);
        g = int'(px[10:5]);
        b = int'(px[4:0]);
        return 24'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4));
    endfunction

    function automatic void model_reset();
        m_p = 0; m_en_prev = 1'b0;
        e_de = 1'b0; e_hs_n = 1'b1; e_vs_n = 1'b1; e_rgb = 24'h0;
        e_uf = 1'b0; e_ucnt = 0;
    endfunction

    function automatic int cur_h();
        return m_p % HT;
    endfunction

    function automatic int cur_v();
        return (m_p / HT) % VT;
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic run_cycle();
        int h, v;
        bit rdy, fs;
        #1;
        h = cur_h(); v = cur_v();
        rdy = enable && (h < HA) && (v < VA);
        fs  = enable && (!m_en_prev || (h == 0 && v == VA));
        n_cmp++;
        if (pixel_ready !== rdy) begin
            n_err++; $display("FAIL ready cyc=%0d: got %b expected %b", cyc, pixel_ready, rdy);
        end
        n_cmp++;
        if (pixel_frame_sync !== fs) begin
            n_err++; $display("FAIL frame_sync cyc=%0d: got %b expected %b", cyc, pixel_frame_sync, fs);
        end
        @(posedge clk);
        if (underflow_clr) begin
            e_uf = 1'b0; e_ucnt = 0;
        end else if (rdy && !pixel_valid) begin
            e_uf = 1'b1;
            if (e_ucnt < 65535) e_ucnt++;
        end
        if (enable) begin
            e_de   = rdy;
            e_rgb  = rdy ? expand(pixel_valid ? pixel_readdata : FILL) : 24'h0;
            e_hs_n = !(h >= HA + HF && h < HA + HF + HS);
            e_vs_n = !(v >= VA + VF && v < VA + VF + VS);
            m_p++;
        end else begin
            e_de = 1'b0; e_hs_n = 1'b1; e_vs_n = 1'b1; e_rgb = 24'h0;
            m_p = 0;
        end
        m_en_prev = enable;
        #1;
        n_cmp++;
        if ({lcd_de, lcd_hsync_n, lcd_vsync_n} !== {e_de, e_hs_n, e_vs_n}) begin
            n_err++; $display("FAIL de/hs/vs cyc=%0d: got %b%b%b expected %b%b%b", cyc,
                              lcd_de, lcd_hsync_n, lcd_vsync_n, e_de, e_hs_n, e_vs_n);
        end
        n_cmp++;
        if (lcd_rgb !== e_rgb) begin
            n_err++; $display("FAIL rgb cyc=%0d: got %h expected %h", cyc, lcd_rgb, e_rgb);
        end
        n_cmp++;
        if (underflow !== e_uf || underflow_cnt !== 16'(e_ucnt)) begin
            n_err++; $display("FAIL underflow cyc=%0d: got %b/%0d expected %b/%0d", cyc,
                              underflow, underflow_cnt, e_uf, e_ucnt);
        end
        cyc++;
    endtask

    // Advance until the model sits on pixel 0 of an active line.
    task automatic wait_line_start(input string tag);
        int n;
        n = 0;
        while (!(cur_h() == 0 && cur_v() < VA) && n < 200) begin
            run_cycle(); n++;
        end
        if (n >= 200) begin
            n_cmp++; n_err++; $display("FAIL %s: timeout waiting for line start", tag);
        end
    endtask

    task automatic test_reset();
        bit rose;
        rst_n = 1'b0; enable = 1'b0; pixel_valid = 1'b0; pixel_readdata = 16'h0; underflow_clr = 1'b0;
        #12;
        n_cmp++;
        if ({pixel_ready, pixel_frame_sync, lcd_de, lcd_hsync_n, lcd_vsync_n, lcd_rgb, underflow, underflow_cnt}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 16'h0}) begin
            n_err++; $display("FAIL reset_values: got de=%b hs=%b vs=%b rgb=%h uf=%b cnt=%0d expected idle",
                              lcd_de, lcd_hsync_n, lcd_vsync_n, lcd_rgb, underflow, underflow_cnt);
        end
        enable = 1'b1;
        #1;
        n_cmp++;
        if ({pixel_ready, pixel_frame_sync} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready: got %b%b expected 00", pixel_ready, pixel_frame_sync);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rose = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            if (pixel_ready) rose = 1'b1;
        end
        n_cmp++;
        if (rose !== 1'b0) begin
            n_err++; $display("FAIL idle_ready: got %b expected 0", rose);
        end
    endtask

    task automatic test_timing();
        int first_de, first_hs, rdy_cnt, bad_align;
        bit prev_rdy;
        first_de = -1; first_hs = -1; rdy_cnt = 0; bad_align = 0; prev_rdy = 1'b0;
        enable = 1'b1; pixel_valid = 1'b1;
        for (int k = 0; k < 2 * HT * VT; k++) begin
            pixel_readdata = 16'($urandom);
            run_cycle();
            if (k > 0 && lcd_de !== prev_rdy) bad_align++;
            if (lcd_de && first_de < 0) first_de = k;
            if (!lcd_hsync_n && first_hs < 0) first_hs = k;
            prev_rdy = pixel_ready;
            if (k < HT && pixel_ready) rdy_cnt++;
        end
        n_cmp++;
        if (rdy_cnt != 8) begin
            n_err++; $display("FAIL ready_duty: got %0d expected 8", rdy_cnt);
        end
        n_cmp++;
        if (first_hs - first_de != 9) begin
            n_err++; $display("FAIL hsync_offset: got %0d expected 9", first_hs - first_de);
        end
        n_cmp++;
        if (bad_align != 0) begin
            n_err++; $display("FAIL de_delay: got %0d misaligned expected 0", bad_align);
        end
    endtask

    task automatic test_expand();
        logic [15:0] pats [3];
        logic [23:0] want [3];
        logic [23:0] got  [3];
        int n;
        pats[0] = 16'hF800; pats[1] = 16'h07E0; pats[2] = 16'h0841;
        want[0] = 24'hFF0000; want[1] = 24'h00FF00; want[2] = 24'h080808;
        pixel_valid = 1'b1;
        wait_line_start("expand");
        n = 0;
        for (int i = 0; i < 3; i++) begin
            pixel_readdata = pats[i];
            run_cycle();
            got[i] = lcd_rgb;
            if (lcd_de) n++;
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got[i] !== want[i] || n != 3) begin
                n_err++; $display("FAIL expand%0d: got %h (de %0d) expected %h", i, got[i], n, want[i]);
            end
        end
    endtask

    task automatic test_underflow();
        int zero_slots;
        underflow_clr = 1'b1; run_cycle(); underflow_clr = 1'b0;
        wait_line_start("underflow");
        zero_slots = 0;
        pixel_readdata = 16'hFFFF;
        pixel_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            if (lcd_de && lcd_rgb == 24'h0) zero_slots++;
        end
        pixel_valid = 1'b1;
        run_cycle();
        n_cmp++;
        if (zero_slots != 3) begin
            n_err++; $display("FAIL fill_slots: got %0d expected 3", zero_slots);
        end
        n_cmp++;
        if (underflow !== 1'b1 || underflow_cnt !== 16'd3) begin
            n_err++; $display("FAIL underflow_3: got %b/%0d expected 1/3", underflow, underflow_cnt);
        end
        underflow_clr = 1'b1; run_cycle(); underflow_clr = 1'b0;
        n_cmp++;
        if (underflow !== 1'b0 || underflow_cnt !== 16'd0) begin
            n_err++; $display("FAIL underflow_clr: got %b/%0d expected 0/0", underflow, underflow_cnt);
        end
    endtask

    task automatic test_frame_sync();
        int pulses, first_at, second_at, bad_pos;
        pulses = 0; first_at = -1; second_at = -1; bad_pos = 0;
        enable = 1'b1; pixel_valid = 1'b1;
        for (int k = 0; k < 2 * HT * VT; k++) begin
            pixel_readdata = 16'($urandom);
            run_cycle();
            if (pixel_frame_sync) begin
                pulses++;
                if (!(cur_h() == 0 && cur_v() == VA)) bad_pos++;
                if (first_at < 0) first_at = k; else if (second_at < 0) second_at = k;
            end
        end
        n_cmp++;
        if (pulses != 2 || bad_pos != 0) begin
            n_err++; $display("FAIL fs_count: got %0d pulses (%0d misplaced) expected 2", pulses, bad_pos);
        end
        n_cmp++;
        if (second_at - first_at != HT * VT) begin
            n_err++; $display("FAIL fs_period: got %0d expected %0d", second_at - first_at, HT * VT);
        end
    endtask

    task automatic test_enable_toggle();
        int n;
        wait_line_start("toggle");
        n = 0;
        while (cur_h() != 3 && n < 20) begin
            run_cycle(); n++;
        end
        enable = 1'b0;
        run_cycle();
        n_cmp++;
        if (lcd_de !== 1'b0 || pixel_ready !== 1'b0) begin
            n_err++; $display("FAIL disable: got de=%b ready=%b expected 0/0", lcd_de, pixel_ready);
        end
        for (int i = 0; i < 3; i++) run_cycle();
        enable = 1'b1;
        #1;
        n_cmp++;
        if (pixel_frame_sync !== 1'b1 || pixel_ready !== 1'b1) begin
            n_err++; $display("FAIL reenable: got fs=%b ready=%b expected 1/1", pixel_frame_sync, pixel_ready);
        end
        run_cycle();
        n_cmp++;
        if (lcd_de !== 1'b1) begin
            n_err++; $display("FAIL restart_de: got %b expected 1", lcd_de);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 700; k++) begin
            enable         = ($urandom_range(0, 39) != 0);
            pixel_valid    = ($urandom_range(0, 5) != 0);
            pixel_readdata = 16'($urandom);
            underflow_clr  = ($urandom_range(0, 29) == 0);
            run_cycle();
        end
        enable = 1'b1; underflow_clr = 1'b0;
    endtask

    task automatic test_reset_midframe();
        pixel_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            pixel_readdata = 16'($urandom);
            run_cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pixel_ready, lcd_de, lcd_hsync_n, lcd_vsync_n, lcd_rgb, underflow, underflow_cnt}
            !== {1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 16'h0}) begin
            n_err++; $display("FAIL async_reset: got de=%b rgb=%h uf=%b cnt=%0d expected idle",
                              lcd_de, lcd_rgb, underflow, underflow_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pixel_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            pixel_readdata = 16'($urandom);
            run_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_expand();
        test_underflow();
        test_frame_sync();
        test_enable_toggle();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
